// File: rtl/pipeline_run_ctrl.sv
// Run/step sequencer for the 5-stage pipeline: turns debug RUN/STEP/ABORT commands
// into the pipeline-advance enable, drains after HALT and counts advance cycles.
module pipeline_run_ctrl #(
  parameter int DRAIN_CYCLES = 4,
  parameter int NB_CNT       = 32
) (
  input  logic              clk,
  input  logic              i_reset,
  input  logic              i_cmd_valid,
  input  logic [1:0]        i_cmd,
  output logic              o_cmd_ready,
  input  logic              i_halt,
  output logic              o_step,
  output logic              o_flush,
  output logic              o_busy,
  output logic              o_done,
  output logic [2:0]        o_state,
  output logic [NB_CNT-1:0] o_cycle_count
);

  localparam int NB_DRN = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [NB_DRN-1:0] DRN_LOAD = NB_DRN'(DRAIN_CYCLES - 1);

  localparam logic [1:0] CMD_RUN   = 2'b01;
  localparam logic [1:0] CMD_STEP  = 2'b10;
  localparam logic [1:0] CMD_ABORT = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RUN       = 3'd1,
    ST_STEP_WAIT = 3'd2,
    ST_STEP_EXEC = 3'd3,
    ST_DRAIN     = 3'd4,
    ST_DONE      = 3'd5
  } state_t;

  state_t              r_state;
  logic [NB_DRN-1:0]   r_drain;
  logic [NB_CNT-1:0]   r_cnt;
  logic                r_flush;
  logic                w_acc;
  logic                w_run;
  logic                w_step_cmd;
  logic                w_abort;
  logic                w_cnt_max;

  // Moore decodes of the state register
  assign o_step      = (r_state == ST_RUN) || (r_state == ST_STEP_EXEC) || (r_state == ST_DRAIN);
  assign o_busy      = o_step;
  assign o_done      = (r_state == ST_DONE);
  assign o_cmd_ready = !((r_state == ST_STEP_EXEC) || (r_state == ST_DRAIN));
  assign o_state     = r_state;
  assign o_flush     = r_flush;
  assign o_cycle_count = r_cnt;

  assign w_acc      = i_cmd_valid && o_cmd_ready;
  assign w_run      = w_acc && (i_cmd == CMD_RUN);
  assign w_step_cmd = w_acc && (i_cmd == CMD_STEP);
  assign w_abort    = w_acc && (i_cmd == CMD_ABORT);
  assign w_cnt_max  = &r_cnt;

  // Sequencer state, drain counter, flush pulse and saturating cycle counter
  always_ff @(posedge clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= ST_IDLE;
      r_drain <= '0;
      r_cnt   <= '0;
      r_flush <= 1'b0;
    end else begin
      r_flush <= 1'b0;
      if (o_step && !w_cnt_max) begin
        r_cnt <= r_cnt + NB_CNT'(1);
      end
      case (r_state)
        ST_IDLE: begin
          if (w_abort) begin
            r_state <= ST_IDLE;
            r_flush <= 1'b1;
            r_cnt   <= '0;
          end else if (w_run) begin
            r_state <= ST_RUN;
            r_cnt   <= '0;
          end else if (w_step_cmd) begin
            r_state <= ST_STEP_EXEC;
            r_cnt   <= '0;
          end
        end
        ST_RUN: begin
          if (w_abort) begin
            r_state <= ST_IDLE;
            r_flush <= 1'b1;
            r_cnt   <= '0;
          end else if (i_halt) begin
            r_state <= ST_DRAIN;
            r_drain <= DRN_LOAD;
          end else if (w_step_cmd) begin
            r_state <= ST_STEP_WAIT;
          end
        end
        ST_STEP_EXEC: begin
          if (i_halt) begin
            r_state <= ST_DRAIN;
            r_drain <= DRN_LOAD;
          end else begin
            r_state <= ST_STEP_WAIT;
          end
        end
        ST_STEP_WAIT: begin
          // Pipeline is frozen here, so a HALT in ID is not acted on
          if (w_abort) begin
            r_state <= ST_IDLE;
            r_flush <= 1'b1;
            r_cnt   <= '0;
          end else if (w_step_cmd) begin
            r_state <= ST_STEP_EXEC;
          end else if (w_run) begin
            r_state <= ST_RUN;
          end
        end
        ST_DRAIN: begin
          if (r_drain == '0) begin
            r_state <= ST_DONE;
          end else begin
            r_drain <= r_drain - NB_DRN'(1);
          end
        end
        ST_DONE: begin
          if (w_abort) begin
            r_state <= ST_IDLE;
            r_flush <= 1'b1;
            r_cnt   <= '0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_run_ctrl.sv
// Scoreboard bench for pipeline_run_ctrl: per-cycle expected outputs are queued with
// the stimulus and compared one cycle later, after the clock edge.
module tb_pipeline_run_ctrl;

  localparam int NB_CNT = 4;

  logic              clk = 1'b0;
  logic              i_reset = 1'b0;
  logic              i_cmd_valid = 1'b0;
  logic [1:0]        i_cmd = 2'b00;
  logic              i_halt = 1'b0;
  logic              o_cmd_ready;
  logic              o_step;
  logic              o_flush;
  logic              o_busy;
  logic              o_done;
  logic [2:0]        o_state;
  logic [NB_CNT-1:0] o_cycle_count;

  localparam logic [1:0] NOP = 2'b00, RUN = 2'b01, STEP = 2'b10, ABORT = 2'b11;
  localparam int S_IDLE = 0, S_RUN = 1, S_WAIT = 2, S_EXEC = 3, S_DRAIN = 4, S_DONE = 5;

  typedef struct {
    int st;
    int flush;
    int cnt;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  pipeline_run_ctrl #(.DRAIN_CYCLES(4), .NB_CNT(NB_CNT)) dut (
    .clk           (clk),
    .i_reset       (i_reset),
    .i_cmd_valid   (i_cmd_valid),
    .i_cmd         (i_cmd),
    .o_cmd_ready   (o_cmd_ready),
    .i_halt        (i_halt),
    .o_step        (o_step),
    .o_flush       (o_flush),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_state       (o_state),
    .o_cycle_count (o_cycle_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, queue what the outputs must be after the edge, then check
  task automatic cyc(input logic v, input logic [1:0] c, input logic h,
                     input int st, input int fl, input int cnt);
    exp_t e;
    i_cmd_valid = v;
    i_cmd       = c;
    i_halt      = h;
    sb_q.push_back('{st: st, flush: fl, cnt: cnt});
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    chk("state", int'(o_state), e.st);
    chk("step",  int'(o_step),  (e.st == S_RUN || e.st == S_EXEC || e.st == S_DRAIN) ? 1 : 0);
    chk("busy",  int'(o_busy),  (e.st == S_RUN || e.st == S_EXEC || e.st == S_DRAIN) ? 1 : 0);
    chk("ready", int'(o_cmd_ready), (e.st == S_EXEC || e.st == S_DRAIN) ? 0 : 1);
    chk("done",  int'(o_done),  (e.st == S_DONE) ? 1 : 0);
    chk("flush", int'(o_flush), e.flush);
    chk("count", int'(o_cycle_count), e.cnt);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    // Reset held for three cycles
    repeat (3) @(posedge clk);
    #1;
    chk("rst_state", int'(o_state), S_IDLE);
    chk("rst_step",  int'(o_step), 0);
    chk("rst_flush", int'(o_flush), 0);
    chk("rst_ready", int'(o_cmd_ready), 1);
    chk("rst_count", int'(o_cycle_count), 0);
    chk("rst_done",  int'(o_done), 0);
    i_reset = 1'b1;
    cyc(1'b0, NOP, 1'b0, S_IDLE, 0, 0);

    // Run to halt: 10 RUN cycles with halt on the 10th, then 4 drain cycles
    cyc(1'b1, RUN, 1'b0, S_RUN, 0, 0);
    for (int k = 1; k <= 9; k++) cyc(1'b0, NOP, 1'b0, S_RUN, 0, k);
    cyc(1'b0, NOP, 1'b1, S_DRAIN, 0, 10);
    for (int d = 1; d <= 4; d++) cyc(1'b0, NOP, 1'b1, (d < 4) ? S_DRAIN : S_DONE, 0, 10 + d);
    cyc(1'b0, NOP, 1'b0, S_DONE, 0, 14);
    cyc(1'b1, RUN, 1'b0, S_DONE, 0, 14);
    cyc(1'b1, STEP, 1'b0, S_DONE, 0, 14);
    cyc(1'b1, ABORT, 1'b0, S_IDLE, 1, 0);
    cyc(1'b0, NOP, 1'b0, S_IDLE, 0, 0);

    // Single stepping; a STEP offered during the pulse is refused
    cyc(1'b1, STEP, 1'b0, S_EXEC, 0, 0);
    cyc(1'b1, STEP, 1'b0, S_WAIT, 0, 1);
    cyc(1'b1, STEP, 1'b0, S_EXEC, 0, 1);
    cyc(1'b0, NOP, 1'b0, S_WAIT, 0, 2);
    cyc(1'b1, STEP, 1'b0, S_EXEC, 0, 2);
    cyc(1'b0, NOP, 1'b0, S_WAIT, 0, 3);
    cyc(1'b0, NOP, 1'b1, S_WAIT, 0, 3);

    // RUN from STEP_WAIT, STEP in RUN, then ABORT beats a simultaneous halt
    cyc(1'b1, RUN, 1'b0, S_RUN, 0, 3);
    cyc(1'b1, STEP, 1'b0, S_WAIT, 0, 4);
    cyc(1'b1, RUN, 1'b0, S_RUN, 0, 4);
    cyc(1'b0, NOP, 1'b0, S_RUN, 0, 5);
    cyc(1'b1, ABORT, 1'b1, S_IDLE, 1, 0);
    cyc(1'b0, NOP, 1'b0, S_IDLE, 0, 0);

    // Step into halt: 1 exec + 4 drain steps; STEP during drain refused
    cyc(1'b1, STEP, 1'b0, S_EXEC, 0, 0);
    cyc(1'b0, NOP, 1'b1, S_DRAIN, 0, 1);
    cyc(1'b1, STEP, 1'b0, S_DRAIN, 0, 2);
    cyc(1'b1, ABORT, 1'b0, S_DRAIN, 0, 3);
    cyc(1'b1, STEP, 1'b0, S_DRAIN, 0, 4);
    cyc(1'b0, NOP, 1'b0, S_DONE, 0, 5);
    cyc(1'b1, ABORT, 1'b0, S_IDLE, 1, 0);

    // Counter saturation at 4 bits, then async reset in the middle of DRAIN
    cyc(1'b1, RUN, 1'b0, S_RUN, 0, 0);
    for (int k = 1; k <= 20; k++) cyc(1'b0, NOP, 1'b0, S_RUN, 0, (k > 15) ? 15 : k);
    cyc(1'b0, NOP, 1'b1, S_DRAIN, 0, 15);
    cyc(1'b0, NOP, 1'b0, S_DRAIN, 0, 15);
    #2;
    i_reset = 1'b0;
    #1;
    chk("arst_state", int'(o_state), S_IDLE);
    chk("arst_step",  int'(o_step), 0);
    chk("arst_busy",  int'(o_busy), 0);
    chk("arst_count", int'(o_cycle_count), 0);
    @(posedge clk);
    #1;
    chk("arst_hold_state", int'(o_state), S_IDLE);
    i_reset = 1'b1;
    cyc(1'b0, NOP, 1'b0, S_IDLE, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
